// File: rtl/vga_sprite_engine_if.sv
// Pixel, motion-control and configuration signals between the VGA timing
// path / processor wrapper and the sprite engine.
interface vga_sprite_engine_if #(
  parameter int NUM_SPRITES = 4,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int COLOR_BITS  = 12
);
  localparam int SEL_W = $clog2(NUM_SPRITES);

  logic                             frame_tick;
  logic                             active;
  logic [X_WIDTH-1:0]               x;
  logic [Y_WIDTH-1:0]               y;
  logic [COLOR_BITS-1:0]            bg_color;
  logic [4*NUM_SPRITES-1:0]         dir;
  logic                             cfg_we;
  logic [SEL_W-1:0]                 cfg_sel;
  logic [2:0]                       cfg_field;
  logic [X_WIDTH+Y_WIDTH-1:0]       cfg_data;
  logic [COLOR_BITS-1:0]            rgb;
  logic                             hit_valid;
  logic [SEL_W-1:0]                 hit_idx;
  logic [NUM_SPRITES-1:0]           coll_flags;
  logic [X_WIDTH*NUM_SPRITES-1:0]   pos_x;
  logic [Y_WIDTH*NUM_SPRITES-1:0]   pos_y;

  modport master (
    output frame_tick, active, x, y, bg_color, dir,
           cfg_we, cfg_sel, cfg_field, cfg_data,
    input  rgb, hit_valid, hit_idx, coll_flags, pos_x, pos_y
  );

  modport slave (
    input  frame_tick, active, x, y, bg_color, dir,
           cfg_we, cfg_sel, cfg_field, cfg_data,
    output rgb, hit_valid, hit_idx, coll_flags, pos_x, pos_y
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// N-sprite renderer: per-sprite registers, once-per-frame motion (manual or
// bounce), fixed-priority compositing and per-frame overlap flags.
module vga_sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int COLOR_BITS  = 12
) (
  input logic                clk,
  input logic                reset,
  vga_sprite_engine_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SPRITES);
  localparam int CW    = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

  logic [X_WIDTH-1:0]    x0_q [NUM_SPRITES], x0_d [NUM_SPRITES];
  logic [X_WIDTH-1:0]    w_q [NUM_SPRITES], w_d [NUM_SPRITES];
  logic [X_WIDTH-1:0]    xmin_q [NUM_SPRITES], xmin_d [NUM_SPRITES];
  logic [X_WIDTH-1:0]    xmax_q [NUM_SPRITES], xmax_d [NUM_SPRITES];
  logic [X_WIDTH-1:0]    vx_q [NUM_SPRITES], vx_d [NUM_SPRITES];
  logic [Y_WIDTH-1:0]    y0_q [NUM_SPRITES], y0_d [NUM_SPRITES];
  logic [Y_WIDTH-1:0]    h_q [NUM_SPRITES], h_d [NUM_SPRITES];
  logic [Y_WIDTH-1:0]    ymin_q [NUM_SPRITES], ymin_d [NUM_SPRITES];
  logic [Y_WIDTH-1:0]    ymax_q [NUM_SPRITES], ymax_d [NUM_SPRITES];
  logic [Y_WIDTH-1:0]    vy_q [NUM_SPRITES], vy_d [NUM_SPRITES];
  logic [COLOR_BITS-1:0] color_q [NUM_SPRITES], color_d [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] mode_q, mode_d, en_q, en_d;

  logic [X_WIDTH-1:0]    mot_x [NUM_SPRITES], mot_vx [NUM_SPRITES];
  logic [Y_WIDTH-1:0]    mot_y [NUM_SPRITES], mot_vy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit, contrib;
  logic [NUM_SPRITES-1:0] acc_q, acc_d, coll_q, coll_d;
  logic [COLOR_BITS-1:0] rgb_q, rgb_d;
  logic                  hit_valid_q, hit_valid_d;
  logic [SEL_W-1:0]      hit_idx_q, hit_idx_d, win;

  // An inverted region (hi < lo) always resolves to the region minimum.
  function automatic logic signed [CW-1:0] clamp_range(
    input logic signed [CW-1:0] v, input logic signed [CW-1:0] lo,
    input logic signed [CW-1:0] hi);
    if (hi < lo)      clamp_range = lo;
    else if (v < lo)  clamp_range = lo;
    else if (v > hi)  clamp_range = hi;
    else              clamp_range = v;
  endfunction

  function automatic logic signed [CW-1:0] bounce_pos(
    input logic signed [CW-1:0] p, input logic signed [CW-1:0] v,
    input logic signed [CW-1:0] lo, input logic signed [CW-1:0] hi);
    if (p + v < lo)      bounce_pos = lo;
    else if (p + v > hi) bounce_pos = (hi < lo) ? lo : hi;
    else                 bounce_pos = p + v;
  endfunction

  function automatic logic bounce_flip(
    input logic signed [CW-1:0] p, input logic signed [CW-1:0] v,
    input logic signed [CW-1:0] lo, input logic signed [CW-1:0] hi);
    bounce_flip = (p + v < lo) || (p + v > hi);
  endfunction

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    logic [3:0]             d;
    logic signed [CW-1:0]   sx, sy, px, py, vxs, vys, lox, hix, loy, hiy;
    logic [X_WIDTH-1:0]     nx, nvx;
    logic [Y_WIDTH-1:0]     ny, nvy;

    assign d   = bus.dir[4*i +: 4];
    assign px  = CW'(x0_q[i]);
    assign py  = CW'(y0_q[i]);
    assign vxs = CW'($signed(vx_q[i]));
    assign vys = CW'($signed(vy_q[i]));
    assign sx  = CW'(vx_q[i][X_WIDTH-1] ? 4'(-vx_q[i]) : vx_q[i][3:0]);
    assign sy  = CW'(vy_q[i][Y_WIDTH-1] ? 4'(-vy_q[i]) : vy_q[i][3:0]);
    assign lox = CW'(xmin_q[i]);
    assign hix = CW'(xmax_q[i]) - CW'(w_q[i]);
    assign loy = CW'(ymin_q[i]);
    assign hiy = CW'(ymax_q[i]) - CW'(h_q[i]);

    // Edge sums carry one extra bit so sprites at the far edge never wrap.
    assign hit[i] = en_q[i]
                 && (bus.x >= x0_q[i])
                 && ({1'b0, bus.x} < {1'b0, x0_q[i]} + {1'b0, w_q[i]})
                 && (bus.y >= y0_q[i])
                 && ({1'b0, bus.y} < {1'b0, y0_q[i]} + {1'b0, h_q[i]});

    always_comb begin
      nx  = x0_q[i];
      nvx = vx_q[i];
      ny  = y0_q[i];
      nvy = vy_q[i];
      if (bus.frame_tick && en_q[i]) begin
        if (mode_q[i]) begin
          nx = X_WIDTH'(bounce_pos(px, vxs, lox, hix));
          ny = Y_WIDTH'(bounce_pos(py, vys, loy, hiy));
          if (bounce_flip(px, vxs, lox, hix)) nvx = -vx_q[i];
          if (bounce_flip(py, vys, loy, hiy)) nvy = -vy_q[i];
        end else begin
          nx = X_WIDTH'(clamp_range(px + (d[0] ? sx : '0) - (d[1] ? sx : '0), lox, hix));
          ny = Y_WIDTH'(clamp_range(py + (d[2] ? sy : '0) - (d[3] ? sy : '0), loy, hiy));
        end
      end
    end

    assign mot_x[i]  = nx;
    assign mot_vx[i] = nvx;
    assign mot_y[i]  = ny;
    assign mot_vy[i] = nvy;
    assign bus.pos_x[i*X_WIDTH +: X_WIDTH] = x0_q[i];
    assign bus.pos_y[i*Y_WIDTH +: Y_WIDTH] = y0_q[i];
  end

  // A config write overrides only the addressed field; motion fills the rest.
  always_comb begin
    x0_d = mot_x;  vx_d = mot_vx;  y0_d = mot_y;  vy_d = mot_vy;
    w_d = w_q;  h_d = h_q;  xmin_d = xmin_q;  ymin_d = ymin_q;
    xmax_d = xmax_q;  ymax_d = ymax_q;  color_d = color_q;
    mode_d = mode_q;  en_d = en_q;
    if (bus.cfg_we) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (bus.cfg_sel == SEL_W'(i)) begin
          case (bus.cfg_field)
            3'd0: begin x0_d[i] = bus.cfg_data[X_WIDTH-1:0]; y0_d[i] = bus.cfg_data[X_WIDTH +: Y_WIDTH]; end
            3'd1: begin w_d[i] = bus.cfg_data[X_WIDTH-1:0]; h_d[i] = bus.cfg_data[X_WIDTH +: Y_WIDTH]; end
            3'd2: begin xmin_d[i] = bus.cfg_data[X_WIDTH-1:0]; ymin_d[i] = bus.cfg_data[X_WIDTH +: Y_WIDTH]; end
            3'd3: begin xmax_d[i] = bus.cfg_data[X_WIDTH-1:0]; ymax_d[i] = bus.cfg_data[X_WIDTH +: Y_WIDTH]; end
            3'd4: begin vx_d[i] = bus.cfg_data[X_WIDTH-1:0]; vy_d[i] = bus.cfg_data[X_WIDTH +: Y_WIDTH]; end
            3'd5: begin
              color_d[i] = bus.cfg_data[COLOR_BITS-1:0];
              mode_d[i]  = bus.cfg_data[COLOR_BITS];
              en_d[i]    = bus.cfg_data[COLOR_BITS+1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    win         = '0;
    rgb_d       = '0;
    hit_valid_d = 1'b0;
    hit_idx_d   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) win = SEL_W'(i);
    end
    if (bus.active) begin
      if (|hit) begin
        rgb_d       = color_q[win];
        hit_valid_d = 1'b1;
        hit_idx_d   = win;
      end else begin
        rgb_d = bus.bg_color;
      end
    end
    // Only pixels covered by two or more sprites count as a collision.
    contrib = (bus.active && ((hit & (hit - NUM_SPRITES'(1))) != '0)) ? hit : '0;
    acc_d   = bus.frame_tick ? '0 : (acc_q | contrib);
    coll_d  = bus.frame_tick ? (acc_q | contrib) : coll_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x0_q[i] <= '0;  w_q[i] <= '0;  xmin_q[i] <= '0;  xmax_q[i] <= '0;  vx_q[i] <= '0;
        y0_q[i] <= '0;  h_q[i] <= '0;  ymin_q[i] <= '0;  ymax_q[i] <= '0;  vy_q[i] <= '0;
        color_q[i] <= '0;
      end
      mode_q      <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      coll_q      <= '0;
      rgb_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      x0_q <= x0_d;  w_q <= w_d;  xmin_q <= xmin_d;  xmax_q <= xmax_d;  vx_q <= vx_d;
      y0_q <= y0_d;  h_q <= h_d;  ymin_q <= ymin_d;  ymax_q <= ymax_d;  vy_q <= vy_d;
      color_q     <= color_d;
      mode_q      <= mode_d;
      en_q        <= en_d;
      acc_q       <= acc_d;
      coll_q      <= coll_d;
      rgb_q       <= rgb_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.hit_valid  = hit_valid_q;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.coll_flags = coll_q;
endmodule
